// File: rtl/counter_pkg.sv
// Shared defaults and the count type for the saturating event/cycle counter.
package counter_pkg;

    localparam int CNT_WIDTH   = 4;
    localparam int CNT_SAT_VAL = 11;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/counter_sat.sv
// Up-counter that either clamps at SAT_VAL (satEn = 1) or wraps modulo 2^WIDTH (satEn = 0).
module counter_sat
    import counter_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH,
    parameter int SAT_VAL = CNT_SAT_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             satEn,
    output logic [WIDTH-1:0] val_out
);

    localparam logic [WIDTH-1:0] SAT_CEIL = WIDTH'(SAT_VAL);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    generate
        if (SAT_VAL >= (2 ** WIDTH)) begin : g_bad_sat_val
            $error("counter_sat: SAT_VAL must be below 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_next;

    // Values above the ceiling (reachable after free-running) clamp straight back to it.
    always_comb begin
        cnt_next = val_out + ONE;
        if (satEn && (val_out >= SAT_CEIL)) begin
            cnt_next = SAT_CEIL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_out <= '0;
        end else begin
            val_out <= cnt_next;
        end
    end

    // One saturating edge is enough to bring any value to or below the ceiling.
    property p_sat_bound;
        @(posedge clk) disable iff (!rst_n)
            (satEn ##1 satEn) |=> (val_out <= SAT_CEIL);
    endproperty
    a_sat_bound : assert property (p_sat_bound);

    property p_reset_zero;
        @(posedge clk) (!rst_n) |-> (val_out == '0);
    endproperty
    a_reset_zero : assert property (p_reset_zero);

endmodule

// File: tb/tb_counter_sat.sv
// Directed and randomized checks of counter_sat against an arithmetic reference model.
module tb_counter_sat;

    localparam int W   = 4;
    localparam int SAT = 11;
    localparam int MOD = 16;

    logic         clk;
    logic         rst_n;
    logic         satEn;
    logic [W-1:0] val_out;

    int checks = 0;
    int errors = 0;
    int model  = 0;

    counter_sat #(.WIDTH(W), .SAT_VAL(SAT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .satEn   (satEn),
        .val_out (val_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic s, input string tag);
        logic [W-1:0] e;
        satEn = s;
        @(posedge clk);
        if (!rst_n)
            model = 0;
        else if (s)
            model = (model < SAT) ? model + 1 : SAT;
        else
            model = (model + 1) % MOD;
        #1;
        e = model[W-1:0];
        check(tag, val_out, e);
    endtask

    // Assert reset on a falling edge, confirm it acts without a rising edge, release one cycle later.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        model = 0;
        #1;
        check(tag, val_out, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] seq_sat [13];
        logic [W-1:0] seq_rel [7];
        rst_n = 1'b0;
        satEn = 1'b0;
        #1;
        check("reset_initial", val_out, 4'd0);
        tick(1'b1, "reset_hold_sat");
        tick(1'b0, "reset_hold_free");
        @(negedge clk);
        rst_n = 1'b1;

        tick(1'b0, "reset_first_edge");
        tick(1'b0, "reset_second_edge");
        pulse_reset("reset_pulse_async");
        tick(1'b0, "reset_pulse_first_edge");

        // Saturation from zero: 1..11 then hold.
        pulse_reset("sat_reset");
        seq_sat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd11, 4'd11};
        for (int i = 0; i < 13; i++) begin
            tick(1'b1, "sat_climb");
            check("sat_climb_table", val_out, seq_sat[i]);
        end

        // Release saturation from 11: keeps counting and wraps.
        seq_rel = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, "release_sat");
            check("release_sat_table", val_out, seq_rel[i]);
        end

        // Clamp from above: free-run to 14, then enable saturation.
        pulse_reset("clamp_reset");
        for (int i = 0; i < 14; i++) tick(1'b0, "clamp_freerun");
        check("clamp_at_14", val_out, 4'd14);
        tick(1'b1, "clamp_down");
        check("clamp_down_11", val_out, 4'd11);
        tick(1'b1, "clamp_hold");
        check("clamp_hold_11", val_out, 4'd11);

        // Mid-count reset at 7.
        pulse_reset("mid_prep_reset");
        for (int i = 0; i < 7; i++) tick(1'b0, "mid_count");
        check("mid_at_7", val_out, 4'd7);
        pulse_reset("mid_async_zero");
        tick(1'b0, "mid_restart");
        check("mid_restart_1", val_out, 4'd1);

        // Free-run wrap over 20 edges.
        pulse_reset("wrap_reset");
        for (int i = 1; i <= 20; i++) begin
            logic [W-1:0] e;
            tick(1'b0, "wrap_run");
            e = W'(i % MOD);
            check("wrap_table", val_out, e);
        end

        // Randomized mode switching with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                pulse_reset("rand_reset");
            tick(1'($urandom_range(0, 1)), "rand_step");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sat.md
# counter_sat

4-bit up-counter with a selectable saturation mode, used as a small event and cycle counter in the datapath. When saturation is enabled, the count climbs to 11 and holds there. When saturation is disabled, it counts freely through 15 and wraps to 0. It is a leaf block with no handshake; consumers sample `val_out` every clock.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits.
- `SAT_VAL`, default 11: saturation ceiling. Must satisfy `SAT_VAL` < 2^`WIDTH`.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `satEn`  input  1: saturation enable. 1 = saturate at `SAT_VAL`; 0 = free-running modulo 2^`WIDTH`.
- `val_out`  output  `WIDTH`: current count, driven directly from the register.

## Operation
- **Reset.** While `rst_n` = 0, `val_out` = 0 regardless of clock or `satEn`.
- **Counting.** When `rst_n` = 1, the counter updates on every rising edge of `clk`. There is no separate count-enable; counting never pauses outside reset.
- **`satEn` = 1, `val_out` < `SAT_VAL`.** Next value is `val_out` + 1.
- **`satEn` = 1, `val_out` ≥ `SAT_VAL`.** Next value is `SAT_VAL`. The counter holds at 11, and any value from 12 to 15 clamps back to 11 on the next edge.
- **`satEn` = 0.** Next value is `val_out` + 1, modulo 2^`WIDTH` (15 → 0 wraps silently). There is no overflow flag.
- **Width.** Arithmetic is unsigned, `WIDTH` bits; the carry out is discarded.
- **Mode switching.** `satEn` may change on any cycle. Its value sampled at a rising edge selects the rule for that edge only; no history is kept.
- **Simultaneous events.** Reset has absolute priority over counting and mode.

## Timing
- Latency: one clock. A `satEn` change sampled at edge N affects the value produced at edge N.
- **Reset assertion** is asynchronous: `val_out` goes to 0 without waiting for a clock edge, including mid-count or while saturated.
- **Reset deassertion** is sampled synchronously:
  - The first rising edge with `rst_n` = 1 produces `val_out` = 1.
  - `rst_n` should be released away from the rising edge, either by a synchronized deassert upstream or by releasing on the negative edge.
- No combinational path from any input to `val_out`.

## Structure
- Shared package `counter_pkg` holds:
  - `localparam` defaults `CNT_WIDTH` = 4 and `CNT_SAT_VAL` = 11;
  - `typedef logic [CNT_WIDTH-1:0] cnt_t`.
- Single module: one register with a next-state mux (reset / clamp / increment). No sub-module is needed.
- Include assertions:
  - `val_out` never exceeds `SAT_VAL` two cycles after `satEn` is held at 1;
  - `val_out` = 0 while `rst_n` = 0.

## Test plan
1. **Reset:** pulse `rst_n` low for one cycle with `satEn` = 0 → `val_out` = 0 immediately; first edge after release → 1.
2. **Saturation:** from 0, `satEn` = 1 for 13 edges → sequence 1, 2, …, 11, 11, 11; holds at 11 thereafter.
3. **Release saturation:** from 11, set `satEn` = 0 for 7 edges → 12, 13, 14, 15, 0, 1, 2.
4. **Clamp from above:** count freely to 14 with `satEn` = 0, then set `satEn` = 1 → next edge 11, then 11 holds.
5. **Mid-count reset:** assert `rst_n` low on a negative edge while `val_out` = 7 → `val_out` = 0 before the next rising edge; after release, the count restarts at 1.
6. **Free-run wrap:** `satEn` = 0 for 20 edges from reset → 1…15, 0, 1, 2, 3, 4; no stall at 15.
